// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer and ctrlunit: opcode map, fetch states, default width.
package fetch_unit_pkg;

    localparam int DEF_WIDTH = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Opcodes 1110/1111 never redirect the PC.
    function automatic logic is_nop_op(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: jump beats taken branch beats sequential; also produces the link value.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_jump,
    input  logic             i_branch,
    input  logic             i_zero,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic [WIDTH-1:0] i_br_offset,
    output logic [WIDTH-1:0] o_next_pc,
    output logic [WIDTH-1:0] o_link_addr
);

    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    // Priority mux; all sums wrap modulo 2^WIDTH.
    always_comb begin
        o_link_addr = i_pc + PC_STEP;
        if (i_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_branch && i_zero) begin
            o_next_pc = o_link_addr + i_br_offset;
        end else begin
            o_next_pc = o_link_addr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over req/ack, presents the instruction for execution.
// Optional FETCH_HALT_EN: opcode 1111 enters a HALT state left only through reset, and adds the halted port.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imemAck,
    input  logic [WIDTH-1:0] imemData,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    input  logic [WIDTH-1:0] jumpTarget,
    input  logic [WIDTH-1:0] brOffset,
    input  logic             stall,
    output logic             imemReq,
    output logic [WIDTH-1:0] imemAddr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr,
    output logic [3:0]       opcode,
    output logic             instrValid,
    output logic [WIDTH-1:0] linkAddr,
    output logic [15:0]      retired
`ifdef FETCH_HALT_EN
    ,
    output logic             halted
`endif
);

    fetch_state_e     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [15:0]      r_retired;
    logic             r_req;
    logic             r_valid;
    logic [3:0]       w_opcode;
    logic             w_is_nop;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_link;
`ifdef FETCH_HALT_EN
    logic             r_halted;
`endif

    assign w_opcode = r_instr[WIDTH-1 -: 4];
    assign w_is_nop = is_nop_op(w_opcode);

    fetch_unit_pc_next #(.WIDTH(WIDTH)) u_pc_next (
        .i_pc          (r_pc),
        .i_jump        (jump & ~w_is_nop),
        .i_branch      (branch & ~w_is_nop),
        .i_zero        (zero),
        .i_jump_target (jumpTarget),
        .i_br_offset   (brOffset),
        .o_next_pc     (w_next_pc),
        .o_link_addr   (w_link)
    );

    // Fetch/execute sequencer; an ack only counts while the request is actually on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= {WIDTH{1'b0}};
            r_retired <= 16'h0000;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (r_req && imemAck) begin
                        r_instr <= imemData;
                        r_state <= ST_EXEC;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 16'd1;
                        r_valid   <= 1'b0;
                        r_state   <= ST_FETCH;
                        r_req     <= 1'b1;
`ifdef FETCH_HALT_EN
                        if (w_opcode == OP_HALT) begin
                            r_state  <= ST_HALT;
                            r_req    <= 1'b0;
                            r_halted <= 1'b1;
                        end
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                ST_HALT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imemReq    = r_req;
    assign imemAddr   = r_pc;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign opcode     = w_opcode;
    assign instrValid = r_valid;
    assign linkAddr   = w_link;
    assign retired    = r_retired;
`ifdef FETCH_HALT_EN
    assign halted     = r_halted;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, random instruction stream vs. reference model, reset/halt corners.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemAck;
    logic [15:0] imemData;
    logic        jump, branch, zero, stall;
    logic [15:0] jumpTarget, brOffset;
    logic        imemReq, instrValid;
    logic [15:0] imemAddr, pc, instr, linkAddr, retired;
    logic [3:0]  opcode;
`ifdef FETCH_HALT_EN
    logic        halted;
`endif

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] m_pc;
    logic [15:0] m_ret;

    typedef struct {
        logic [15:0] word;
        int          lat;
        bit          j, b, z;
        logic [15:0] tgt, off;
        int          nstall;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    fetch_unit dut (
        .clk(clk), .rst(rst), .imemAck(imemAck), .imemData(imemData),
        .jump(jump), .branch(branch), .zero(zero), .jumpTarget(jumpTarget),
        .brOffset(brOffset), .stall(stall), .imemReq(imemReq), .imemAddr(imemAddr),
        .pc(pc), .instr(instr), .opcode(opcode), .instrValid(instrValid),
        .linkAddr(linkAddr), .retired(retired)
`ifdef FETCH_HALT_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference next PC straight from the ISA rules.
    function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [3:0] op,
                                             input bit j, input bit b, input bit z,
                                             input logic [15:0] tgt, input logic [15:0] off);
        if (op == 4'hE || op == 4'hF) return p + 16'd1;
        if (j) return tgt;
        if (b && z) return p + 16'd1 + off;
        return p + 16'd1;
    endfunction

    // One instruction: fetch with given ack latency, execute with given controls and stall length.
    task automatic do_instr(input logic [15:0] w, input int lat, input bit j, input bit b, input bit z,
                            input logic [15:0] tgt, input logic [15:0] off, input int nst);
        int guard = 0;
        while (imemReq !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("fetch_req", {31'd0, imemReq}, 32'd1);
        check("fetch_addr", {16'd0, imemAddr}, {16'd0, m_pc});
        check("fetch_valid", {31'd0, instrValid}, 32'd0);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            check("req_held", {15'd0, imemReq, imemAddr}, {15'd0, 1'b1, m_pc});
            check("wait_valid", {31'd0, instrValid}, 32'd0);
        end
        imemAck = 1'b1;
        imemData = w;
        @(negedge clk);
        imemAck = 1'b0;
        imemData = $urandom;
        check("exec_valid", {31'd0, instrValid}, 32'd1);
        check("exec_instr", {16'd0, instr}, {16'd0, w});
        check("exec_opcode", {28'd0, opcode}, {28'd0, w[15:12]});
        check("exec_pc", {16'd0, pc}, {16'd0, m_pc});
        check("exec_link", {16'd0, linkAddr}, {16'd0, m_pc + 16'd1});
        check("exec_noreq", {31'd0, imemReq}, 32'd0);
        check("exec_retired", {16'd0, retired}, {16'd0, m_ret});
        jump = j; branch = b; zero = z; jumpTarget = tgt; brOffset = off;
        stall = (nst > 0);
        for (int k = 0; k < nst; k++) begin
            imemAck = 1'b1;
            imemData = ~w;
            @(negedge clk);
            imemAck = 1'b0;
            check("stall_state", {instr, pc}, {w, m_pc});
            check("stall_retired", {15'd0, instrValid, retired}, {15'd0, 1'b1, m_ret});
        end
        stall = 1'b0;
        @(negedge clk);
        m_pc = ref_next(m_pc, w[15:12], j, b, z, tgt, off);
        m_ret = m_ret + 16'd1;
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        check("post_retired", {16'd0, retired}, {16'd0, m_ret});
    endtask

    initial begin
        vecs[0]  = '{16'h0123, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0001};
        vecs[1]  = '{16'h0456, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002};
        vecs[2]  = '{16'h0789, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0003};
        vecs[3]  = '{16'h0ABC, 3, 0, 0, 0, 16'h0000, 16'h0000, 4, 16'h0004};
        vecs[4]  = '{16'h9000, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0010};
        vecs[5]  = '{16'hA000, 1, 1, 0, 0, 16'h0200, 16'h0000, 0, 16'h0200};
        vecs[6]  = '{16'h9000, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0010};
        vecs[7]  = '{16'h8000, 2, 0, 1, 1, 16'h0000, 16'hFFFE, 0, 16'h000F};
        vecs[8]  = '{16'h9000, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0010};
        vecs[9]  = '{16'h8000, 0, 0, 1, 0, 16'h0000, 16'hFFFE, 1, 16'h0011};
        vecs[10] = '{16'h8000, 0, 1, 1, 1, 16'h0300, 16'h0005, 0, 16'h0300};
        vecs[11] = '{16'h9000, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 0, 16'hFFFF};
        vecs[12] = '{16'h0111, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000};
        vecs[13] = '{16'hE000, 0, 1, 1, 1, 16'h1234, 16'h0040, 0, 16'h0001};

        rst = 1'b1; imemAck = 1'b0; imemData = 16'h0000; jump = 1'b0; branch = 1'b0;
        zero = 1'b0; stall = 1'b0; jumpTarget = 16'h0000; brOffset = 16'h0000;
        m_pc = 16'h0000; m_ret = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_outputs", {14'd0, imemReq, instrValid, retired}, 32'd0);
        check("rst_pc_instr", {pc, instr}, 32'd0);
`ifdef FETCH_HALT_EN
        check("rst_halted", {31'd0, halted}, 32'd0);
`endif
        rst = 1'b0;
        #1 check("req_before_edge", {31'd0, imemReq}, 32'd0);
        @(negedge clk);
        check("first_req", {15'd0, imemReq, imemAddr}, {15'd0, 1'b1, 16'h0000});

        for (int i = 0; i < 14; i++) begin
            do_instr(vecs[i].word, vecs[i].lat, vecs[i].j, vecs[i].b, vecs[i].z,
                     vecs[i].tgt, vecs[i].off, vecs[i].nstall);
            check($sformatf("tbl_pc_%0d", i), {16'd0, pc}, {16'd0, vecs[i].exp_pc});
            if (i == 2) check("retired_3", {16'd0, retired}, 32'd3);
        end

        // Retired counter wrap: preload just below the top.
        force dut.r_retired = 16'hFFFE;
        #1 release dut.r_retired;
        m_ret = 16'hFFFE;
        do_instr(16'h0001, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        do_instr(16'h0002, 1, 0, 0, 0, 16'h0000, 16'h0000, 0);
        check("retired_wrap", {16'd0, retired}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
`ifdef FETCH_HALT_EN
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
`endif
            do_instr(w, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                     16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset asserted mid-fetch takes effect without a clock edge.
        imemAck = 1'b0;
        @(negedge clk);
        check("prereset_req", {31'd0, imemReq}, 32'd1);
        rst = 1'b1;
        #1;
        check("midfetch_req", {31'd0, imemReq}, 32'd0);
        check("midfetch_pc", {15'd0, instrValid, pc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 16'h0000; m_ret = 16'h0000;
        do_instr(16'h0333, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
        check("after_reset_pc", {16'd0, pc}, 32'd1);

        do_instr(16'hF000, 0, 1, 0, 0, 16'h0555, 16'h0000, 0);
`ifdef FETCH_HALT_EN
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", {16'd0, pc}, 32'd2);
        for (int k = 0; k < 20; k++) begin
            imemAck = 1'($urandom);
            @(negedge clk);
            check("halt_idle", {14'd0, imemReq, instrValid, retired}, {14'd0, 2'b00, m_ret});
        end
        imemAck = 1'b0;
        rst = 1'b1;
        #1 check("halt_reset", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        check("nop_f_pc", {16'd0, pc}, 32'd2);
        do_instr(16'h0444, 0, 0, 0, 0, 16'h0000, 16'h0000, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer.
- Owns the PC and requests 16-bit instructions from instruction memory over a req/ack handshake.
- Presents the latched instruction and its opcode to ctrlunit and the datapath.
- Consumes ctrlunit's jump/branch outputs plus the ALU zero flag to select the next PC.
- Sits between instruction memory and ctrlunit, at the opposite end of the opcode interface.

Parameters:
- WIDTH, 16: PC, address and instruction width.
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- imemAck  input  1  instruction memory has valid imemData this cycle.
- imemData  input  WIDTH  instruction word from memory.
- jump  input  1  from ctrlunit; take jumpTarget.
- branch  input  1  from ctrlunit; conditional branch.
- zero  input  1  ALU zero flag (Rs - Rt == 0).
- jumpTarget  input  WIDTH  absolute jump address from the datapath.
- brOffset  input  WIDTH  sign-extended branch offset from the datapath.
- stall  input  1  datapath busy (e.g. data memory); hold EXEC.
- imemReq  output  1  fetch request.
- imemAddr  output  WIDTH  fetch address (= pc).
- pc  output  WIDTH  current PC.
- instr  output  WIDTH  latched instruction register.
- opcode  output  4  instr[15:12], drives ctrlunit.opcode.
- instrValid  output  1  instr is valid and executing.
- linkAddr  output  WIDTH  pc+1, the JAL link value.
- retired  output  16  count of completed instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch or mid-exec):
  - pc=RESET_PC, instr=0, state=FETCH, retired=0.
  - imemReq=0 and instrValid=0 while rst is high.
  - The first request is issued on the first clk edge after rst deasserts.
- States: FETCH, EXEC (plus HALT when the optional feature is enabled).
- FETCH:
  - imemReq=1 and imemAddr=pc, held stable until imemAck.
  - imemAck may arrive in the same cycle as the request (zero-wait memory).
  - On the ack edge: instr<=imemData, go to EXEC.
  - Without ack: stay in FETCH, request held.
  - instrValid=0 throughout.
- EXEC:
  - instrValid=1, imemReq=0. ctrlunit decodes opcode combinationally.
  - stall=1: hold EXEC; pc and instr unchanged.
  - stall=0, at the edge, select the next PC by priority:
    - jump=1: pc<=jumpTarget.
    - else branch=1 and zero=1: pc<=pc+1+brOffset.
    - else: pc<=pc+1.
  - On that same edge: retired<=retired+1, go to FETCH.
- jump and branch both high: jump wins.
- Throughput: 2 cycles/instruction minimum with zero-wait memory.
- Arithmetic is modulo 2^WIDTH: pc 16'hFFFF+1 wraps to 0; negative brOffset wraps; retired wraps 16'hFFFF->0.
- linkAddr=pc+1 is combinational and valid throughout EXEC.
- imemAck outside FETCH is ignored.
- Opcodes 4'b1110 and 4'b1111 execute as NOP: pc+1.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - Opcode 4'b1111 in EXEC with stall=0 moves to HALT, with pc<=pc+1 and retired incremented.
  - In HALT: imemReq=0, instrValid=0, all state frozen; exit only by rst.
  - Adds output halted (1 bit, 1 in HALT, 0 at reset).
- Undefined: 4'b1111 is a NOP, no HALT state, no halted port.

Decomposition:
- Shared package holds:
  - Opcode constants (ADD..JAL, 4'b1110, 4'b1111).
  - State encodings FETCH/EXEC/HALT.
  - The WIDTH default.
- ctrlunit and fetch_unit both use the opcode constants.
- One natural sub-module, pc_next: combinational next-PC mux (pc, jump, branch, zero, jumpTarget, brOffset -> nextPc, linkAddr).

Test Plan:
- Reset then zero-wait memory of ADD words:
  - Cycle 1: imemReq=1, imemAddr=0.
  - Then EXEC with pc 0,1,2 on successive pairs of cycles; retired=3 after 6 cycles.
- Memory with 3-cycle ack latency:
  - imemReq held 3 cycles at a stable address; instrValid only after ack.
  - imemAck pulsed during EXEC is ignored.
- Jump and branch:
  - pc=0x0010, JAL with jump=1, jumpTarget=0x0200: linkAddr=0x0011, next imemAddr=0x0200.
  - BRZ with zero=1, brOffset=0xFFFE: next pc=0x000F.
  - BRZ with zero=0: next pc=0x0011.
  - jump=1 and branch=1 together: jumpTarget is taken.
- Wrap-around:
  - pc=0xFFFF with sequential ADD: next pc=0x0000.
  - retired preloaded near 0xFFFF wraps to 0.
- Stall and reset:
  - stall=1 for 4 EXEC cycles: pc and instr stable, retired unchanged.
  - rst pulsed mid-FETCH: imemReq drops without a clock edge; pc=RESET_PC.
- With FETCH_HALT_EN: executing 4'b1111 sets halted=1 and imemReq stays 0 for 20 cycles.
- Without FETCH_HALT_EN: executing 4'b1111 increments pc.
